spi_slave_rx_mode3: RTL and testbench

Downstream receiver for the SPI mode-3 transmitter (CPOL=1, CPHA=1, MSB first, active-low CS). It oversamples CS_n, SCLK and MOSI in the system clock domain and reassembles bytes. Each completed byte is presented with a one-cycle valid pulse. It is the loopback/consumer stage used to close the TX path in simulation and on-board tests.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 51 +++++
 rtl/spi_slave_rx_mode3.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_rx_mode3.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-3 receive path: FSM encoding, clock mode
// and the idle levels the input synchronizers reset to.
package spi_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  localparam int CPOL = 1;
  localparam int CPHA = 1;

  localparam logic CS_N_IDLE = 1'b1;
  localparam logic SCLK_IDLE = 1'(CPOL);
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with an optional
// one-cycle rise/fall pulse computed on the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0,
  parameter bit   EDGE_EN     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // Fewer than two stages would not give metastability time to settle.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          prev_q <= RESET_VAL;
        end else begin
          prev_q <= q_o;
        end
      end

      assign rise_o = q_o & ~prev_q;
      assign fall_o = ~q_o & prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 receiver: oversamples CS_n/SCLK/MOSI and emits each completed word
// with a one-cycle valid pulse. Define SPI_RX_FRAME_ERR_EN to add Out_rx_err.
module spi_slave_rx_mode3
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              In_clk,
  input  logic              In_rst_n,
  input  logic              In_spi_cs_n,
  input  logic              In_spi_sclk,
  input  logic              In_spi_mosi,
  output logic [DATA_W-1:0] Out_rx_data,
  output logic              Out_rx_valid,
  output logic              Out_rx_busy
`ifdef SPI_RX_FRAME_ERR_EN
  ,
  output logic              Out_rx_err
`endif
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_n_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              word_done;
`ifdef SPI_RX_FRAME_ERR_EN
  logic              err_q, err_d;
`endif

  // The sclk edge detector tracks its previous sample every cycle, so on entry
  // to RECV it already holds the current level and cannot fake an edge.
  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (SCLK_IDLE),
    .EDGE_EN    (1'b1)
  ) u_sclk_sync (
    .clk_i (In_clk),
    .rst_ni(In_rst_n),
    .d_i   (In_spi_sclk),
    .q_o   (sclk_sync),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (CS_N_IDLE),
    .EDGE_EN    (1'b0)
  ) u_cs_sync (
    .clk_i (In_clk),
    .rst_ni(In_rst_n),
    .d_i   (In_spi_cs_n),
    .q_o   (cs_n_sync),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (MOSI_IDLE),
    .EDGE_EN    (1'b0)
  ) u_mosi_sync (
    .clk_i (In_clk),
    .rst_ni(In_rst_n),
    .d_i   (In_spi_mosi),
    .q_o   (mosi_sync),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  logic sync_unused;
  assign sync_unused = ^{sclk_sync, sclk_fall, cs_rise, cs_fall,
                         mosi_rise, mosi_fall, shift_q[DATA_W-1]};

  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign word_done = (state_q == ST_RECV) && sclk_rise && (bit_cnt_q == LAST_BIT);

  // A word finishing in the same cycle CS releases still completes; anything
  // shorter is dropped with the counter cleared for the next frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!cs_n_sync) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
        end
      end
      ST_RECV: begin
        if (sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_sync};
          if (bit_cnt_q == LAST_BIT) begin
            data_d    = shift_d;
            valid_d   = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (cs_n_sync) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
`ifdef SPI_RX_FRAME_ERR_EN
          err_d     = (bit_cnt_q != '0) && !word_done;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
`ifdef SPI_RX_FRAME_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign Out_rx_data  = data_q;
  assign Out_rx_valid = valid_q;
  assign Out_rx_busy  = (state_q == ST_RECV);
`ifdef SPI_RX_FRAME_ERR_EN
  assign Out_rx_err   = err_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Randomised scoreboard bench for spi_slave_rx_mode3: a mode-3 master model
// pushes expected words with their landing cycle, a monitor pops and compares.
module tb_spi_slave_rx_mode3;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs_n  = 1'b1;
  logic              sclk  = 1'b1;
  logic              mosi  = 1'b0;
  logic [DATA_W-1:0] rxData;
  logic              rxValid;
  logic              rxBusy;
`ifdef SPI_RX_FRAME_ERR_EN
  logic              rxErr;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t              expQ[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  logic [DATA_W-1:0] lastData = '0;
  int                errExp   = 0;
  int                errSeen  = 0;

  spi_slave_rx_mode3 #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .In_clk      (clk),
    .In_rst_n    (rst_n),
    .In_spi_cs_n (cs_n),
    .In_spi_sclk (sclk),
    .In_spi_mosi (mosi),
    .Out_rx_data (rxData),
    .Out_rx_valid(rxValid),
    .Out_rx_busy (rxBusy)
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    .Out_rx_err  (rxErr)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input int phase);
    cs_n = 1'b0;
    waitCycles(phase);
  endtask

  task automatic endFrame(input int phase);
    cs_n = 1'b1;
    waitCycles(phase);
  endtask

  // Mode 3: MOSI changes on the falling edge, the slave samples on the rising
  // edge; a full word lands SYNC_STAGES+1 cycles after its raw 8th rise.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input int nbits,
                               input int phase, input bit csWithLast);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = d[DATA_W-1-i];
      waitCycles(phase);
      sclk = 1'b1;
      if (i == DATA_W - 1) begin
        exp_t e;
        e.data   = d;
        e.cyc    = cyc + SYNC_STAGES + 1;
        expQ.push_back(e);
        lastData = d;
        if (csWithLast) cs_n = 1'b1;
      end
      waitCycles(phase);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rxValid) begin
      if (expQ.size() == 0) begin
        checkOutput("valid_without_word", {31'b0, rxValid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rx_data", {24'b0, rxData}, {24'b0, e.data});
        checkOutput("valid_cycle", cyc, e.cyc);
      end
    end
`ifdef SPI_RX_FRAME_ERR_EN
    if (rst_n && rxErr) errSeen++;
`endif
  end

  initial begin
    int phase;
    int nw;
    int nb;

    waitCycles(3);
    checkOutput("reset_data", {24'b0, rxData}, 32'd0);
    checkOutput("reset_valid", {31'b0, rxValid}, 32'd0);
    checkOutput("reset_busy", {31'b0, rxBusy}, 32'd0);
`ifdef SPI_RX_FRAME_ERR_EN
    checkOutput("reset_err", {31'b0, rxErr}, 32'd0);
`endif
    rst_n = 1'b1;
    waitCycles(3);

    // Loopback at the 50 MHz / 50 kHz operating point.
    startFrame(500);
    applyStimulus(8'h12, 8, 500, 1'b0);
    checkOutput("busy_in_frame", {31'b0, rxBusy}, 32'd1);
    endFrame(500);
    checkOutput("busy_after_cs", {31'b0, rxBusy}, 32'd0);
    checkOutput("loopback_data", {24'b0, rxData}, 32'h12);

    // Two words in one frame.
    startFrame(50);
    applyStimulus(8'h55, 8, 50, 1'b0);
    checkOutput("busy_between_words", {31'b0, rxBusy}, 32'd1);
    applyStimulus(8'hA3, 8, 50, 1'b0);
    checkOutput("busy_in_frame", {31'b0, rxBusy}, 32'd1);
    endFrame(50);
    checkOutput("busy_after_cs", {31'b0, rxBusy}, 32'd0);

    // Truncated word: 5 bits of 8'hFF.
    startFrame(50);
    applyStimulus(8'hFF, 5, 50, 1'b0);
    endFrame(50);
    errExp++;
    checkOutput("data_hold_trunc", {24'b0, rxData}, {24'b0, lastData});
    checkOutput("busy_after_trunc", {31'b0, rxBusy}, 32'd0);

    // Reset mid-word.
    startFrame(8);
    applyStimulus(8'h0F, 3, 8, 1'b0);
    checkOutput("busy_before_reset", {31'b0, rxBusy}, 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_data", {24'b0, rxData}, 32'd0);
    checkOutput("midreset_valid", {31'b0, rxValid}, 32'd0);
    checkOutput("midreset_busy", {31'b0, rxBusy}, 32'd0);
    lastData = '0;
    cs_n = 1'b1;
    sclk = 1'b1;
    waitCycles(4);
    rst_n = 1'b1;
    waitCycles(4);
    startFrame(8);
    applyStimulus(8'h81, 8, 8, 1'b0);
    endFrame(8);
    checkOutput("after_reset_data", {24'b0, rxData}, 32'h81);

    // SCLK activity while deselected must be ignored.
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0;
      waitCycles(4);
      sclk = 1'b1;
      waitCycles(4);
    end
    checkOutput("busy_while_deselected", {31'b0, rxBusy}, 32'd0);
    startFrame(8);
    applyStimulus(8'h00, 8, 8, 1'b0);
    endFrame(8);

    // Minimum phase length; landing cycle checked by the monitor.
    startFrame(4);
    applyStimulus(8'hC5, 8, 4, 1'b0);
    endFrame(4);
    checkOutput("minphase_data", {24'b0, rxData}, 32'hC5);

    // CS release in the same cycle as the final rising edge.
    startFrame(6);
    applyStimulus(8'($urandom), 8, 6, 1'b1);
    waitCycles(6);
    checkOutput("busy_after_cs_with_last", {31'b0, rxBusy}, 32'd0);

    // Randomised frames, some ending in a truncated word.
    for (int f = 0; f < 8; f++) begin
      phase = $urandom_range(4, 12);
      nw    = $urandom_range(1, 3);
      startFrame(phase);
      for (int w = 0; w < nw; w++) begin
        applyStimulus(8'($urandom), 8, phase, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) begin
        nb = $urandom_range(1, 7);
        applyStimulus(8'($urandom), nb, phase, 1'b0);
        errExp++;
      end
      endFrame(phase);
      checkOutput("rand_busy_after_cs", {31'b0, rxBusy}, 32'd0);
      checkOutput("rand_data_hold", {24'b0, rxData}, {24'b0, lastData});
    end

    for (int i = 0; i < 200 && expQ.size() != 0; i++) waitCycles(1);
    checkOutput("pending_words", expQ.size(), 32'd0);
`ifdef SPI_RX_FRAME_ERR_EN
    checkOutput("err_pulses", errSeen, errExp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
